// File: rtl/seven_segment_display_driver.sv
// Registered hex-to-seven-segment decoder for one display digit, with lamp test,
// blanking and a free-running blink timer. Segment bit order is g..a (bit6..bit0).
module seven_segment_display_driver #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter logic [31:0] BLINK_DIV  = 32'd25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hex_digit,
    input  logic       blank,
    input  logic       lamp_test,
    input  logic       blink_en,
    output logic [6:0] hex_display
);

    localparam logic [31:0] LP_TERM = BLINK_DIV - 32'd1;
    localparam logic [6:0]  LP_DARK = ACTIVE_LOW ? 7'h7F : 7'h00;

    // Lit-segment pattern (1 = segment on), independent of board polarity.
    function automatic logic [6:0] decode_lit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] apply_polarity(input logic [6:0] lit);
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    logic [31:0] r_cnt;
    logic        r_phase;
    logic [6:0]  r_display;
    logic [6:0]  w_lit;

    // Timer runs whether or not blinking is enabled; phase 1 is the dark half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b0;
        end else if (r_cnt >= LP_TERM) begin
            r_cnt   <= 32'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        w_lit = decode_lit(hex_digit);
        if (lamp_test) begin
            w_lit = 7'h7F;
        end else if (blank || (blink_en && r_phase)) begin
            w_lit = 7'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_display <= LP_DARK;
        end else begin
            r_display <= apply_polarity(w_lit);
        end
    end

    assign hex_display = r_display;

endmodule

// File: tb/tb_seven_segment_display_driver.sv
// Scoreboard bench: a reference model queues the expected display for every clock edge,
// a monitor pops and compares; directed checks pin the documented encodings.
module tb_seven_segment_display_driver;

    localparam int DIV_A = 4;
    localparam int DIV_B = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hex_digit = 4'h0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic       blink_en = 1'b0;
    logic [6:0] disp_a;
    logic [6:0] disp_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
    } exp_t;

    exp_t exp_q[$];
    longint k_edges = 0;

    always #5 clk = ~clk;

    seven_segment_display_driver #(.ACTIVE_LOW(1'b1), .BLINK_DIV(32'd4)) dut_a (
        .clk(clk), .rst(rst), .hex_digit(hex_digit), .blank(blank),
        .lamp_test(lamp_test), .blink_en(blink_en), .hex_display(disp_a)
    );

    seven_segment_display_driver #(.ACTIVE_LOW(1'b0), .BLINK_DIV(32'd3)) dut_b (
        .clk(clk), .rst(rst), .hex_digit(hex_digit), .blank(blank),
        .lamp_test(lamp_test), .blink_en(blink_en), .hex_display(disp_b)
    );

    function automatic string seg_letters(input logic [3:0] d);
        case (d)
            4'h0: return "abcdef";
            4'h1: return "bc";
            4'h2: return "abdeg";
            4'h3: return "abcdg";
            4'h4: return "bcfg";
            4'h5: return "acdfg";
            4'h6: return "acdefg";
            4'h7: return "abc";
            4'h8: return "abcdefg";
            4'h9: return "abcdfg";
            4'hA: return "abcefg";
            4'hB: return "cdefg";
            4'hC: return "adef";
            4'hD: return "bcdeg";
            4'hE: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    function automatic logic [6:0] lit_of(input logic [3:0] d);
        string s;
        logic [6:0] p;
        p = 7'h00;
        s = seg_letters(d);
        for (int i = 0; i < s.len(); i++) p[int'(s[i]) - int'("a")] = 1'b1;
        return p;
    endfunction

    function automatic logic [6:0] model(input bit active_low, input bit dark_phase,
                                         input logic [3:0] d, input bit bl, input bit lt,
                                         input bit be);
        logic [6:0] p;
        if (lt) p = 7'h7F;
        else if (bl || (be && dark_phase)) p = 7'h00;
        else p = lit_of(d);
        return active_low ? ~p : p;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase derived from the number of clock edges since reset release.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            k_edges = 0;
            e.a = 7'h7F;
            e.b = 7'h00;
        end else begin
            e.a = model(1'b1, ((k_edges / DIV_A) % 2) == 1, hex_digit, blank, lamp_test, blink_en);
            e.b = model(1'b0, ((k_edges / DIV_B) % 2) == 1, hex_digit, blank, lamp_test, blink_en);
            k_edges++;
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 7'h01, 7'h00);
        end else begin
            e = exp_q.pop_front();
            chk("sb_active_low", disp_a, e.a);
            chk("sb_active_high", disp_b, e.b);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] dd[4];
        logic [6:0] ee[4];
        dd = '{4'h3, 4'hC, 4'h9, 4'h5};
        ee = '{7'h30, 7'h46, 7'h10, 7'h12};

        repeat (2) @(negedge clk);
        chk("reset_state_a", disp_a, 7'h7F);
        chk("reset_state_b", disp_b, 7'h00);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            hex_digit = dd[i];
            @(negedge clk);
            chk("decode_directed", disp_a, ee[i]);
            if (i == 0) chk("polarity_digit3", disp_b, 7'h4F);
            @(negedge clk);
        end
        for (int d = 0; d < 16; d++) begin
            hex_digit = 4'(d);
            @(negedge clk);
        end

        hex_digit = 4'h8;
        #2 rst = 1'b1;
        #1 chk("async_reset_a", disp_a, 7'h7F);
        chk("async_reset_b", disp_b, 7'h00);
        @(negedge clk);
        chk("reset_hold", disp_a, 7'h7F);
        rst = 1'b0;
        #1 chk("no_load_before_edge", disp_a, 7'h7F);
        @(negedge clk);
        chk("first_edge_load", disp_a, 7'h00);

        hex_digit = 4'h1;
        blank = 1'b1;
        @(negedge clk);
        chk("blank", disp_a, 7'h7F);
        lamp_test = 1'b1;
        @(negedge clk);
        chk("lamp_over_blank_a", disp_a, 7'h00);
        chk("lamp_over_blank_b", disp_b, 7'h7F);
        blank = 1'b0;
        lamp_test = 1'b0;
        @(negedge clk);
        chk("restore_digit1", disp_a, 7'h79);

        rst = 1'b1;
        hex_digit = 4'h0;
        blink_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk("blink_sequence", disp_a, (j <= 4) ? 7'h40 : 7'h7F);
        end
        blink_en = 1'b0;
        @(negedge clk);
        chk("blink_clear", disp_a, 7'h40);

        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            hex_digit = 4'($urandom_range(0, 15));
            blank     = ($urandom_range(0, 7) == 0);
            lamp_test = ($urandom_range(0, 9) == 0);
            blink_en  = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end

        rst = 1'b0;
        blank = 1'b0;
        lamp_test = 1'b0;
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
